// File: rtl/router_pkg.sv
// Shared types and header-field layout for the router source arbiter.
package router_pkg;

  typedef enum logic [2:0] {IDLE, HDR, PAY, PAR, GAP} arb_state_e;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_ADDR_W  = 2;
  localparam int HDR_LEN_W   = HDR_LEN_MSB - HDR_ADDR_W + 1;

  // Payload length carried in the upper bits of a header byte.
  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [7:0] b);
    return b[HDR_LEN_LSB +: HDR_LEN_W];
  endfunction

endpackage

// File: rtl/router_rr_picker.sv
// Combinational masked round-robin: first requester at or after i_ptr, wrapping to the lowest.
module router_rr_picker #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_any
);

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_hi;
  logic [N_REQ-1:0] w_sel;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign w_mask[gi] = (IDW'(gi) >= i_ptr);
    end
  endgenerate

  assign w_hi  = i_req & w_mask;
  assign w_sel = (|w_hi) ? w_hi : i_req;
  // Isolate the lowest set bit of the selected vector.
  assign o_pick = w_sel & (~w_sel + N_REQ'(1));
  assign o_any  = |i_req;

endmodule

// File: rtl/router_src_arbiter.sv
// Packet-level round-robin arbiter feeding the router source port with pkt_valid framing.
// Optional parity checking is enabled by defining ROUTER_ARB_PARITY_CHK_EN.
module router_src_arbiter
  import router_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic               i_clock,
  input  logic               i_resetn,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ*8-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  input  logic               i_busy,
  output logic [7:0]         o_data_in,
  output logic               o_pkt_valid,
  output logic               o_underrun,
  output logic               o_par_err
);

  arb_state_e             r_state;
  logic [IDW-1:0]         r_ptr;
  logic [IDW-1:0]         r_gidx;
  logic [N_REQ-1:0]       r_grant;
  logic [HDR_LEN_W-1:0]   r_cnt;
  logic [7:0]             r_data;
  logic                   r_pkt_valid;
  logic                   r_underrun;

  logic [N_REQ-1:0]       w_pick;
  logic                   w_any;
  logic [IDW-1:0]         w_pick_idx;
  logic [IDW-1:0]         w_next_ptr;
  logic [7:0]             w_byte;
  logic                   w_gvalid;
  logic                   w_active;
  logic [N_REQ-1:0]       w_ready;
  logic                   w_xfer;

  router_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req  (i_req_valid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  always_comb begin
    w_byte     = '0;
    w_gvalid   = 1'b0;
    w_pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_byte   = i_req_data[8*i +: 8];
        w_gvalid = i_req_valid[i];
      end
      if (w_pick[i]) w_pick_idx = IDW'(i);
    end
  end

  assign w_active   = (r_state == HDR) || (r_state == PAY) || (r_state == PAR);
  assign w_ready    = r_grant & {N_REQ{w_active & ~i_busy}};
  assign w_xfer     = |(i_req_valid & w_ready);
  assign w_next_ptr = (r_gidx == IDW'(N_REQ-1)) ? '0 : r_gidx + 1'b1;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_data      <= 8'h00;
      r_pkt_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      // Owner stalled the stream while the router could have taken a byte.
      r_underrun <= w_active & ~i_busy & ~w_gvalid;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
            r_state <= HDR;
          end
        end
        HDR: begin
          if (w_xfer) begin
            r_data      <= w_byte;
            r_pkt_valid <= 1'b1;
            r_cnt       <= hdr_len(w_byte);
            r_state     <= (hdr_len(w_byte) != '0) ? PAY : PAR;
          end
        end
        PAY: begin
          if (w_xfer) begin
            r_data      <= w_byte;
            r_pkt_valid <= 1'b1;
            r_cnt       <= r_cnt - 1'b1;
            if (r_cnt == HDR_LEN_W'(1)) r_state <= PAR;
          end
        end
        PAR: begin
          if (w_xfer) begin
            r_data      <= w_byte;
            r_pkt_valid <= 1'b0;
            r_ptr       <= w_next_ptr;
            r_grant     <= '0;
            r_state     <= GAP;
          end
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_ARB_PARITY_CHK_EN
  logic [7:0] r_xor;
  logic       r_par_err;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_xor     <= 8'h00;
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          HDR:     r_xor     <= w_byte;
          PAY:     r_xor     <= r_xor ^ w_byte;
          PAR:     r_par_err <= (w_byte != r_xor);
          default: r_xor     <= r_xor;
        endcase
      end
    end
  end

  assign o_par_err = r_par_err;
`else
  assign o_par_err = 1'b0;
`endif

  assign o_req_ready = w_ready;
  assign o_grant     = r_grant;
  assign o_data_in   = r_data;
  assign o_pkt_valid = r_pkt_valid;
  assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_router_src_arbiter.sv
// Bench for router_src_arbiter: per-cycle vector table, rotation and reset sequences, random traffic vs packet model.
module tb_router_src_arbiter;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic            busy = 1'b0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic [7:0]      data_in;
  logic            pkt_valid;
  logic            underrun;
  logic            par_err;

  always #5 clk = ~clk;

  router_src_arbiter #(.N_REQ(NR)) dut (
    .i_clock     (clk),
    .i_resetn    (resetn),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_grant     (grant),
    .i_busy      (busy),
    .o_data_in   (data_in),
    .o_pkt_valid (pkt_valid),
    .o_underrun  (underrun),
    .o_par_err   (par_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic [7:0]    d;
    logic          b;
    logic [NR-1:0] rdy;
    logic [NR-1:0] gnt;
    logic [7:0]    dout;
    logic          pv;
    logic          ur;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [NR-1:0] v, input logic [7:0] d, input logic b,
                     input logic [NR-1:0] rdy, input logic [NR-1:0] gnt,
                     input logic [7:0] dout, input logic pv, input logic ur);
    vec_t e;
    e.v = v; e.d = d; e.b = b; e.rdy = rdy; e.gnt = gnt; e.dout = dout; e.pv = pv; e.ur = ur;
    tbl.push_back(e);
  endtask

  // Packet-level model state: byte queues per requester, rotation pointer, last router-side values.
  logic [7:0] q[NR][$];
  int         m_ptr;
  int         m_since;
  logic [7:0] m_data;
  logic       m_pv;
  int         glog[$];

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (p + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NR; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_since = 1; m_data = 8'h00; m_pv = 1'b0;
    for (int i = 0; i < NR; i++) q[i].delete();
    glog.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; req_valid = '0; busy = 1'b0; req_data = '0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data", 32'(data_in), 32'd0);
    chk("rst_pv", 32'(pkt_valid), 32'd0);
    chk("rst_ur", 32'(underrun), 32'd0);
    chk("rst_pe", 32'(par_err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic add_pkt(input int r, input int len, input bit bad);
    logic [7:0] h, b, x;
    h = {6'(len), 2'($urandom)};
    q[r].push_back(h);
    x = h;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      q[r].push_back(b);
      x = x ^ b;
    end
    q[r].push_back(bad ? (x ^ 8'h5A) : x);
  endtask

  task automatic run_engine(input bit rnd, input int budget);
    int owner = -1;
    int rem = 0;
    bit hdr_next = 1'b0;
    logic [7:0] xr = 8'h00;
    logic exp_ur, exp_pe;
    logic [NR-1:0] v;
    logic b;
    bit t;
    logic [7:0] by;
    int cyc = 0;
    while ((owner != -1 || any_pending()) && cyc < budget) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        v[i] = (q[i].size() > 0) && (!rnd || $urandom_range(5) != 0);
        req_data[8*i +: 8] = v[i] ? q[i][0] : 8'($urandom);
      end
      b = rnd && ($urandom_range(4) == 0);
      req_valid = v;
      busy = b;
      #1;
      chk("eng_ready", 32'(req_ready), (owner >= 0 && !b) ? (32'd1 << owner) : 32'd0);
      t      = (owner >= 0) && !b && v[owner];
      exp_ur = (owner >= 0) && !b && !v[owner];
      exp_pe = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (t) begin
        by = q[owner].pop_front();
        m_data = by;
        if (hdr_next) begin
          hdr_next = 1'b0;
          rem = int'(by[7:2]) + 1;
          m_pv = 1'b1;
          xr = by;
          $display("pkt: req%0d hdr %02h len %0d", owner, by, by[7:2]);
        end else if (rem > 1) begin
          rem--;
          m_pv = 1'b1;
          xr = xr ^ by;
        end else begin
          m_pv = 1'b0;
`ifdef ROUTER_ARB_PARITY_CHK_EN
          exp_pe = (by != xr);
`endif
          m_ptr = (owner + 1) % NR;
          owner = -1;
          m_since = 0;
        end
      end else if (owner == -1) begin
        if (m_since >= 1 && v != '0) begin
          owner = rr_pick(v, m_ptr);
          hdr_next = 1'b1;
          glog.push_back(owner);
        end
        m_since = 1;
      end
      chk("eng_grant", 32'(grant), (owner >= 0) ? (32'd1 << owner) : 32'd0);
      chk("eng_data", 32'(data_in), 32'(m_data));
      chk("eng_pv", 32'(pkt_valid), 32'(m_pv));
      chk("eng_ur", 32'(underrun), 32'(exp_ur));
      chk("eng_pe", 32'(par_err), 32'(exp_pe));
    end
    chk("eng_drained", 32'((owner != -1) || any_pending()), 32'd0);
    req_valid = '0;
    busy = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Hdr 0D L=3, then L=0 packet, underrun mid-payload, busy stall on payload byte 2.
    add(4'h1, 8'h0D, 0, 4'h0, 4'h1, 8'h00, 0, 0);
    add(4'h1, 8'h0D, 0, 4'h1, 4'h1, 8'h0D, 1, 0);
    add(4'h1, 8'h11, 0, 4'h1, 4'h1, 8'h11, 1, 0);
    add(4'h1, 8'h22, 0, 4'h1, 4'h1, 8'h22, 1, 0);
    add(4'h1, 8'h33, 0, 4'h1, 4'h1, 8'h33, 1, 0);
    add(4'h1, 8'h1D, 0, 4'h1, 4'h0, 8'h1D, 0, 0);
    add(4'h0, 8'h00, 0, 4'h0, 4'h0, 8'h1D, 0, 0);
    add(4'h1, 8'h02, 0, 4'h0, 4'h1, 8'h1D, 0, 0);
    add(4'h1, 8'h02, 0, 4'h1, 4'h1, 8'h02, 1, 0);
    add(4'h1, 8'h02, 0, 4'h1, 4'h0, 8'h02, 0, 0);
    add(4'h0, 8'h00, 0, 4'h0, 4'h0, 8'h02, 0, 0);
    add(4'h1, 8'h08, 0, 4'h0, 4'h1, 8'h02, 0, 0);
    add(4'h1, 8'h08, 0, 4'h1, 4'h1, 8'h08, 1, 0);
    add(4'h1, 8'hAA, 0, 4'h1, 4'h1, 8'hAA, 1, 0);
    add(4'h0, 8'hAA, 0, 4'h1, 4'h1, 8'hAA, 1, 1);
    add(4'h1, 8'hBB, 0, 4'h1, 4'h1, 8'hBB, 1, 0);
    add(4'h1, 8'h19, 0, 4'h1, 4'h0, 8'h19, 0, 0);
    add(4'h0, 8'h00, 0, 4'h0, 4'h0, 8'h19, 0, 0);
    add(4'h2, 8'h12, 0, 4'h0, 4'h2, 8'h19, 0, 0);
    add(4'h2, 8'h12, 0, 4'h2, 4'h2, 8'h12, 1, 0);
    add(4'h2, 8'h01, 0, 4'h2, 4'h2, 8'h01, 1, 0);
    add(4'h2, 8'h02, 1, 4'h0, 4'h2, 8'h01, 1, 0);
    add(4'h2, 8'h02, 1, 4'h0, 4'h2, 8'h01, 1, 0);
    add(4'h0, 8'h02, 1, 4'h0, 4'h2, 8'h01, 1, 0);
    add(4'h2, 8'h02, 1, 4'h0, 4'h2, 8'h01, 1, 0);
    add(4'h2, 8'h02, 1, 4'h0, 4'h2, 8'h01, 1, 0);
    add(4'h2, 8'h02, 0, 4'h2, 4'h2, 8'h02, 1, 0);
    add(4'h2, 8'h03, 0, 4'h2, 4'h2, 8'h03, 1, 0);
    add(4'h2, 8'h04, 0, 4'h2, 4'h2, 8'h04, 1, 0);
    add(4'h2, 8'h16, 0, 4'h2, 4'h0, 8'h16, 0, 0);
    add(4'h0, 8'h00, 0, 4'h0, 4'h0, 8'h16, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      req_valid = tbl[i].v;
      req_data  = {NR{tbl[i].d}};
      busy      = tbl[i].b;
      #1;
      chk($sformatf("t%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      $display("vec %0d: v=%h d=%02h busy=%0d -> grant=%h data_in=%02h pkt_valid=%0d underrun=%0d",
               i, tbl[i].v, tbl[i].d, tbl[i].b, grant, data_in, pkt_valid, underrun);
      chk($sformatf("t%0d_grant", i), 32'(grant), 32'(tbl[i].gnt));
      chk($sformatf("t%0d_data", i), 32'(data_in), 32'(tbl[i].dout));
      chk($sformatf("t%0d_pv", i), 32'(pkt_valid), 32'(tbl[i].pv));
      chk($sformatf("t%0d_ur", i), 32'(underrun), 32'(tbl[i].ur));
    end

    // All four requesters continuously valid: grants must rotate 0,1,2,3,0,1,2,3.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NR; r++) add_pkt(r, k + r % 2, 1'b0);
    run_engine(1'b0, 500);
    chk("rr_count", 32'(glog.size()), 32'd8);
    for (int i = 0; i < glog.size() && i < 8; i++)
      chk($sformatf("rr_order%0d", i), 32'(glog[i]), 32'(i % NR));

    // Random traffic with drops, busy and occasional bad parity.
    do_reset();
    for (int k = 0; k < 40; k++)
      add_pkt($urandom_range(NR-1), $urandom_range(6), $urandom_range(3) == 0);
    run_engine(1'b1, 20000);

    // Asynchronous reset in the middle of a payload, then a clean packet.
    do_reset();
    @(negedge clk);
    req_valid = 4'h1; req_data = {NR{8'h14}};
    @(negedge clk);
    @(negedge clk);
    req_data = {NR{8'h55}};
    @(negedge clk);
    #1;
    chk("mid_pv_before", 32'(pkt_valid), 32'd1);
    chk("mid_data_before", 32'(data_in), 32'h55);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_data", 32'(data_in), 32'd0);
    chk("arst_pv", 32'(pkt_valid), 32'd0);
    chk("arst_ur", 32'(underrun), 32'd0);
    chk("arst_pe", 32'(par_err), 32'd0);
    req_valid = '0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    add_pkt(2, 3, 1'b0);
    add_pkt(1, 0, 1'b1);
    run_engine(1'b0, 200);
    chk("post_rst_first", 32'(glog.size() > 0 ? glog[0] : -1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
